// File: rtl/jtag_host_pkg.sv
// Shared types and TMS sequences for the JTAG host scan engine.
// Contents:
//   cmd_type_e - host command encoding (TAP_RESET, IDLE, SCAN_IR, SCAN_DR)
//   state_e    - scan FSM states
//   TMS_*      - TMS sequences, LSB driven first, with their TCK counts
package jtag_host_pkg;

  typedef enum logic [1:0] {
    CMD_TAP_RESET = 2'd0,
    CMD_IDLE      = 2'd1,
    CMD_SCAN_IR   = 2'd2,
    CMD_SCAN_DR   = 2'd3
  } cmd_type_e;

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_READY = 4'd1,
    S_TRST  = 4'd2,
    S_TLR   = 4'd3,
    S_PRE   = 4'd4,
    S_SHIFT = 4'd5,
    S_POST  = 4'd6,
    S_IDLE  = 4'd7,
    S_RSP   = 4'd8
  } state_e;

  localparam int unsigned TMS_SEQ_W = 6;

  // Five ones walk any TAP state to Test-Logic-Reset, the trailing zero lands in Run-Test/Idle.
  localparam logic [TMS_SEQ_W-1:0] TMS_RESET_SEQ  = 6'b01_1111;
  localparam int unsigned          TMS_RESET_TCKS = 6;

  // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [TMS_SEQ_W-1:0] TMS_PRE_DR      = 6'b00_0001;
  localparam int unsigned          TMS_PRE_DR_TCKS = 3;

  // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [TMS_SEQ_W-1:0] TMS_PRE_IR      = 6'b00_0011;
  localparam int unsigned          TMS_PRE_IR_TCKS = 4;

  // Exit1 -> Update -> Run-Test/Idle
  localparam logic [TMS_SEQ_W-1:0] TMS_POST      = 6'b00_0001;
  localparam int unsigned          TMS_POST_TCKS = 2;

  // TCK periods TRSTn is held low for a TAP_RESET command.
  localparam int unsigned TRST_TCKS = 2;

endpackage

// File: rtl/jtag_host_tckgen.sv
// TCK divider. Counts 0..CLK_DIV-1 while enabled and toggles TCK at the
// terminal count. o_rise/o_fall are high in the clk cycle that ends with
// TCK going high/low. When disabled the count restarts and TCK holds.
// Ports:
//   i_clk, i_rstn - system clock, async active-low reset
//   i_en          - run the divider
//   o_tck         - divided clock, resets low
//   o_rise/o_fall - edge strobes, one clk wide
module jtag_host_tckgen #(
  parameter int unsigned CLK_DIV = 5
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  output logic o_tck,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned   CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tck;
  logic          w_tc;

  assign w_tc   = i_en && (r_cnt == TC);
  assign o_rise = w_tc && !r_tck;
  assign o_fall = w_tc && r_tck;
  assign o_tck  = r_tck;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_host_scan.sv
// JTAG host scan engine: turns TAP_RESET / IDLE / SCAN_IR / SCAN_DR commands
// into TCK/TMS/TDI waveforms and returns the captured TDO bits.
// Ports:
//   clk_i, rstn_i           - system clock, async active-low reset
//   cmd_valid_i/ready_o     - command handshake; type, len (clamped to MAX_LEN), data (LSB first)
//   rsp_valid_o/ready_i     - response handshake; rsp_data_o bit i = TDO of shift bit i
//   jtag_tck/tms/tdi/trstn  - to the target TAP; jtag_tdo_i from it
//
// state   | meaning
// INIT    | after reset: release TRSTn, TMS 1,1,1,1,1,0 -> Run-Test/Idle
// READY   | accepting a command
// TRST    | TAP_RESET: TRSTn low for 2 TCK periods, TCK held low at the pin
// TLR     | TAP_RESET: TMS 1,1,1,1,1,0 then respond
// PRE     | walk Run-Test/Idle to Shift-IR/DR
// SHIFT   | len bits, TMS high on the last one
// POST    | Exit1 -> Update -> Run-Test/Idle
// IDLE    | len TCKs with TMS=0
// RSP     | response held until accepted
module jtag_host_scan
  import jtag_host_pkg::*;
#(
  parameter  int unsigned CLK_DIV = 5,
  parameter  int unsigned MAX_LEN = 64,
  localparam int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_type_i,
  input  logic [LW-1:0]      cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               jtag_tck_o,
  output logic               jtag_tms_o,
  output logic               jtag_tdi_o,
  output logic               jtag_trstn_o,
  input  logic               jtag_tdo_i
);

  localparam int unsigned   IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE_L     = LW'(1);

  state_e                 r_state;
  logic [LW-1:0]          r_cnt;
  logic [LW-1:0]          r_len;
  logic [TMS_SEQ_W-1:0]   r_tms_seq;
  logic [MAX_LEN-1:0]     r_sh;
  logic [MAX_LEN-1:0]     r_cap;
  logic                   r_fall_d;
  logic                   r_tms;
  logic                   r_tdi;
  logic                   r_trstn;
  logic                   r_cmd_ready;
  logic                   r_rsp_valid;
  logic [MAX_LEN-1:0]     r_rsp_data;

  logic                   w_tck;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_tck_en;
  logic [LW-1:0]          w_len;
  logic [IW-1:0]          w_bit_idx;
  cmd_type_e              w_type;

  assign w_tck_en  = (r_state != S_READY) && (r_state != S_RSP);
  assign w_len     = (cmd_len_i > MAX_LEN_L) ? MAX_LEN_L : cmd_len_i;
  assign w_bit_idx = IW'(r_len - r_cnt);
  assign w_type    = cmd_type_e'(cmd_type_i);

  jtag_host_tckgen #(
    .CLK_DIV (CLK_DIV)
  ) u_tckgen (
    .i_clk  (clk_i),
    .i_rstn (rstn_i),
    .i_en   (w_tck_en),
    .o_tck  (w_tck),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // The divider keeps running through TRST so the 2 TCK periods are timed,
  // but the target must see no edges while TRSTn is low.
  assign jtag_tck_o   = w_tck & (r_state != S_TRST);
  assign jtag_tms_o   = r_tms;
  assign jtag_tdi_o   = r_tdi;
  assign jtag_trstn_o = r_trstn;
  assign cmd_ready_o  = r_cmd_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;

  // Every TCK period ends on r_fall_d, one clk after TCK falls, so TMS/TDI
  // change well away from the rising edge that samples them.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_INIT;
      r_cnt       <= LW'(TMS_RESET_TCKS);
      r_len       <= '0;
      r_tms_seq   <= TMS_RESET_SEQ;
      r_sh        <= '0;
      r_cap       <= '0;
      r_fall_d    <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_trstn     <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_fall_d <= w_fall;
      case (r_state)
        S_INIT, S_TLR: begin
          r_trstn <= 1'b1;
          if (r_fall_d) begin
            if (r_cnt == ONE_L) begin
              r_tms <= 1'b0;
              if (r_state == S_INIT) begin
                r_state     <= S_READY;
                r_cmd_ready <= 1'b1;
              end else begin
                r_state     <= S_RSP;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
              end
            end else begin
              r_cnt     <= r_cnt - ONE_L;
              r_tms_seq <= r_tms_seq >> 1;
              r_tms     <= r_tms_seq[1];
            end
          end
        end

        S_READY: begin
          if (cmd_valid_i) begin
            r_cmd_ready <= 1'b0;
            r_len       <= w_len;
            r_sh        <= cmd_data_i;
            r_cap       <= '0;
            r_tdi       <= 1'b0;
            case (w_type)
              CMD_TAP_RESET: begin
                r_state <= S_TRST;
                r_trstn <= 1'b0;
                r_cnt   <= LW'(TRST_TCKS);
                r_tms   <= 1'b1;
              end
              CMD_IDLE: begin
                r_tms <= 1'b0;
                r_cnt <= w_len;
                if (w_len == '0) begin
                  r_state     <= S_RSP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                end else begin
                  r_state <= S_IDLE;
                end
              end
              default: begin
                if (w_len == '0) begin
                  r_state     <= S_RSP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                end else begin
                  r_state   <= S_PRE;
                  r_tms     <= 1'b1;
                  r_tms_seq <= (w_type == CMD_SCAN_IR) ? TMS_PRE_IR : TMS_PRE_DR;
                  r_cnt     <= (w_type == CMD_SCAN_IR) ? LW'(TMS_PRE_IR_TCKS)
                                                       : LW'(TMS_PRE_DR_TCKS);
                end
              end
            endcase
          end
        end

        S_TRST: begin
          if (r_fall_d) begin
            if (r_cnt == ONE_L) begin
              r_state   <= S_TLR;
              r_trstn   <= 1'b1;
              r_tms_seq <= TMS_RESET_SEQ;
              r_cnt     <= LW'(TMS_RESET_TCKS);
              r_tms     <= 1'b1;
            end else begin
              r_cnt <= r_cnt - ONE_L;
            end
          end
        end

        S_PRE: begin
          if (r_fall_d) begin
            if (r_cnt == ONE_L) begin
              r_state <= S_SHIFT;
              r_cnt   <= r_len;
              r_tms   <= (r_len == ONE_L);
              r_tdi   <= r_sh[0];
            end else begin
              r_cnt     <= r_cnt - ONE_L;
              r_tms_seq <= r_tms_seq >> 1;
              r_tms     <= r_tms_seq[1];
            end
          end
        end

        S_SHIFT: begin
          if (w_rise) begin
            r_cap[w_bit_idx] <= jtag_tdo_i;
          end
          if (r_fall_d) begin
            if (r_cnt == ONE_L) begin
              r_state   <= S_POST;
              r_tms_seq <= TMS_POST;
              r_cnt     <= LW'(TMS_POST_TCKS);
              r_tms     <= 1'b1;
              r_tdi     <= 1'b0;
            end else begin
              r_cnt <= r_cnt - ONE_L;
              r_sh  <= r_sh >> 1;
              r_tdi <= r_sh[1];
              r_tms <= (r_cnt == LW'(2));
            end
          end
        end

        S_POST: begin
          if (r_fall_d) begin
            if (r_cnt == ONE_L) begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= r_cap;
              r_tms       <= 1'b0;
            end else begin
              r_cnt     <= r_cnt - ONE_L;
              r_tms_seq <= r_tms_seq >> 1;
              r_tms     <= r_tms_seq[1];
            end
          end
        end

        S_IDLE: begin
          if (r_fall_d) begin
            if (r_cnt == ONE_L) begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              r_cnt <= r_cnt - ONE_L;
            end
          end
        end

        S_RSP: begin
          if (rsp_ready_i) begin
            r_state     <= S_READY;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end

        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host_scan.sv
module tb_jtag_host_scan;

  localparam int CLK_DIV = 5;
  localparam int MAX_LEN = 64;
  localparam int LW      = 7;
  localparam int TCLK    = 10;

  localparam logic [31:0] IDCODE = 32'h0000_1025;  // VERSION=0, PART=1, MANUF=0x12
  localparam logic [31:0] DTMCS  = 32'h0000_1320;  // idle=1, abits=0x32, version=0

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type = 2'd0;
  logic [LW-1:0]      cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               jtag_tck, jtag_tms, jtag_tdi, jtag_trstn;
  logic               tap_tdo = 1'b0;

  jtag_host_scan #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_type_i   (cmd_type),
    .cmd_len_i    (cmd_len),
    .cmd_data_i   (cmd_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .jtag_tck_o   (jtag_tck),
    .jtag_tms_o   (jtag_tms),
    .jtag_tdi_o   (jtag_tdi),
    .jtag_trstn_o (jtag_trstn),
    .jtag_tdo_i   (tap_tdo)
  );

  always #(TCLK/2) clk = ~clk;

  // ---------------- target TAP model: IR 5 bits, IDCODE=0x01, DTMCS=0x10 ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;

  function automatic tap_e tap_next(tap_e s, logic tms);
    case (s)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SELDR : RTI;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDR  : PADR;
      PADR:    return tms ? EX2DR : PADR;
      EX2DR:   return tms ? UPDR  : SHDR;
      UPDR:    return tms ? SELDR : RTI;
      SELIR:   return tms ? TLR   : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPIR  : PAIR;
      PAIR:    return tms ? EX2IR : PAIR;
      EX2IR:   return tms ? UPIR  : SHIR;
      default: return tms ? SELDR : RTI;
    endcase
  endfunction

  tap_e        tap_st = TLR;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  tap_irsr = 5'h0;
  logic [31:0] tap_dr = 32'h0;

  always @(posedge jtag_tck or negedge jtag_trstn) begin
    if (!jtag_trstn) begin
      tap_st <= TLR;
      tap_ir <= 5'h01;
    end else begin
      tap_st <= tap_next(tap_st, jtag_tms);
      case (tap_st)
        TLR:   tap_ir <= 5'h01;
        CAPDR: tap_dr <= (tap_ir == 5'h01) ? IDCODE : (tap_ir == 5'h10) ? DTMCS : 32'h0;
        SHDR:  tap_dr <= {jtag_tdi, tap_dr[31:1]};
        CAPIR: tap_irsr <= 5'b00001;
        SHIR:  tap_irsr <= {jtag_tdi, tap_irsr[4:1]};
        UPIR:  tap_ir <= tap_irsr;
        default: ;
      endcase
    end
  end

  always @(negedge jtag_tck or negedge jtag_trstn) begin
    if (!jtag_trstn) tap_tdo <= 1'b0;
    else tap_tdo <= (tap_st == SHDR) ? tap_dr[0] : (tap_st == SHIR) ? tap_irsr[0] : 1'b0;
  end

  // ---------------- pin monitors ----------------
  int         rises = 0;
  int         tms_ones = 0;
  int         arm_count = -1;
  logic [7:0] tms_log = 8'h0;
  time        t_first_rise = 0, t_last_fall = 0, t_rsp_rise = 0, t_acc = 0;

  always @(posedge jtag_tck) begin
    rises   <= rises + 1;
    tms_log <= {tms_log[6:0], jtag_tms};
    if (jtag_tms) tms_ones <= tms_ones + 1;
    if (rises == arm_count) t_first_rise <= $time;
  end
  always @(negedge jtag_tck) t_last_fall <= $time;
  always @(posedge rsp_valid) t_rsp_rise <= $time;
  always @(posedge clk) if (cmd_valid && cmd_ready) t_acc <= $time;

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int k = 0;
    while (!cmd_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    ok = cmd_ready;
    if (!ok) check({name, "_ready_timeout"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic wait_rsp(input string name, output bit ok);
    int k = 0;
    while (!rsp_valid && k < 3000) begin
      @(negedge clk);
      k++;
    end
    ok = rsp_valid;
    if (!ok) check({name, "_rsp_timeout"}, 64'(rsp_valid), 64'd1);
  endtask

  task automatic send(input logic [1:0] t, input logic [LW-1:0] len,
                      input logic [63:0] data, input string name, output bit ok);
    wait_ready(name, ok);
    if (ok) begin
      arm_count = rises;
      cmd_type  = t;
      cmd_len   = len;
      cmd_data  = data;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    typ;
    logic [LW-1:0] len;
    logic [63:0]   data;
    logic [63:0]   exp_data;
    int            exp_rises;
    int            exp_ones;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    bit          ok;
    int          r0, o0, bad;
    logic [63:0] held;

    vecs[0]  = '{2'd3, 7'd32,  64'h0, 64'h0000_1025, 37, 3};
    vecs[1]  = '{2'd2, 7'd5,   64'h10, 64'h01, 11, 4};
    vecs[2]  = '{2'd3, 7'd32,  64'h0, 64'h0000_1320, 37, 3};
    vecs[3]  = '{2'd3, 7'd32,  64'h1234_5678, 64'h0000_1320, 37, 3};
    vecs[4]  = '{2'd1, 7'd7,   64'hFFFF, 64'h0, 7, 0};
    vecs[5]  = '{2'd3, 7'd0,   64'hFF, 64'h0, 0, 0};
    vecs[6]  = '{2'd2, 7'd0,   64'h1F, 64'h0, 0, 0};
    vecs[7]  = '{2'd2, 7'd5,   64'h01, 64'h01, 11, 4};
    vecs[8]  = '{2'd3, 7'd100, 64'hDEAD_BEEF_CAFE_F00D, 64'hCAFE_F00D_0000_1025, 69, 3};
    vecs[9]  = '{2'd2, 7'd5,   64'h10, 64'h01, 11, 4};
    vecs[10] = '{2'd0, 7'd9,   64'h0, 64'h0, 6, 5};
    vecs[11] = '{2'd3, 7'd8,   64'h0, 64'h25, 13, 3};
    vecs[12] = '{2'd1, 7'd1,   64'h0, 64'h0, 1, 0};
    vecs[13] = '{2'd2, 7'd5,   64'h10, 64'h01, 11, 4};
    vecs[14] = '{2'd3, 7'd16,  64'h0, 64'h1320, 21, 3};
    vecs[15] = '{2'd1, 7'd0,   64'h0, 64'h0, 0, 0};

    // reset values
    repeat (3) @(negedge clk);
    check("reset_pins", {58'h0, jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, cmd_ready, rsp_valid},
          64'b01_0000);
    check("reset_data", rsp_data, 64'h0);

    // INIT sequence
    rstn = 1'b1;
    wait_ready("init", ok);
    check("init_rises", 64'(rises), 64'd6);
    check("init_tms", 64'(tms_log[5:0]), 64'b11_1110);
    check("init_tap_rti", 64'(tap_st), 64'(RTI));
    check("init_trstn", 64'(jtag_trstn), 64'd1);

    // table
    for (int i = 0; i < NV; i++) begin
      r0 = rises;
      o0 = tms_ones;
      send(vecs[i].typ, vecs[i].len, vecs[i].data, $sformatf("v%0d", i), ok);
      if (ok) wait_rsp($sformatf("v%0d", i), ok);
      if (ok) begin
        check($sformatf("v%0d_data", i), rsp_data, vecs[i].exp_data);
        check($sformatf("v%0d_rises", i), 64'(rises - r0), 64'(vecs[i].exp_rises));
        check($sformatf("v%0d_tms_ones", i), 64'(tms_ones - o0), 64'(vecs[i].exp_ones));
        check($sformatf("v%0d_tap_rti", i), 64'(tap_st), 64'(RTI));
        check($sformatf("v%0d_pins_idle", i), {62'h0, jtag_tck, jtag_tms}, 64'h0);
        if (vecs[i].exp_rises > 0) begin
          check($sformatf("v%0d_rsp_after_fall", i), 64'(t_rsp_rise - t_last_fall), 64'(TCLK));
          if (vecs[i].typ != 2'd0)
            check($sformatf("v%0d_first_rise_lat", i),
                  64'((t_first_rise > t_acc) && (t_first_rise - t_acc <= 2 * CLK_DIV * TCLK)), 64'd1);
        end
        take_rsp();
      end
    end

    // response held while rsp_ready stays low
    send(2'd3, 7'd32, 64'h0, "hold", ok);
    if (ok) wait_rsp("hold", ok);
    if (ok) begin
      held = rsp_data;
      check("hold_data", held, 64'h1320);
      r0 = rises;
      bad = 0;
      repeat (50) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0 || jtag_tck !== 1'b0) bad++;
      end
      check("hold_stable", 64'(bad), 64'd0);
      check("hold_no_tck", 64'(rises - r0), 64'd0);
      take_rsp();
    end

    // cmd_valid while busy is ignored and not queued
    r0 = rises;
    send(2'd1, 7'd20, 64'h0, "busy", ok);
    if (ok) begin
      bad = 0;
      cmd_type  = 2'd0;
      cmd_valid = 1'b1;
      repeat (30) begin
        @(negedge clk);
        if (cmd_ready !== 1'b0) bad++;
      end
      cmd_valid = 1'b0;
      check("busy_not_ready", 64'(bad), 64'd0);
      wait_rsp("busy", ok);
    end
    if (ok) begin
      check("busy_rises", 64'(rises - r0), 64'd20);
      check("busy_data", rsp_data, 64'h0);
      take_rsp();
      r0 = rises;
      repeat (40) @(negedge clk);
      check("busy_no_queue", {62'h0, rsp_valid, cmd_ready}, 64'b01);
      check("busy_no_tck", 64'(rises - r0), 64'd0);
    end

    // leave a nonzero response behind, then reset in the middle of a DR scan
    send(2'd2, 7'd5, 64'h01, "pre_abort", ok);
    if (ok) wait_rsp("pre_abort", ok);
    if (ok) take_rsp();
    r0 = rises;
    send(2'd3, 7'd32, 64'h0, "abort", ok);
    if (ok) begin
      bad = 0;
      while (rises - r0 < 10 && bad < 2000) begin
        @(negedge clk);
        bad++;
      end
      check("abort_reached_shift", 64'(rises - r0 >= 10), 64'd1);
      #2 rstn = 1'b0;
      #1;
      check("abort_reset_pins",
            {58'h0, jtag_tck, jtag_tms, jtag_tdi, jtag_trstn, cmd_ready, rsp_valid}, 64'b01_0000);
      check("abort_reset_data", rsp_data, 64'h0);
      repeat (3) @(negedge clk);
      r0 = rises;
      rstn = 1'b1;
      bad = 0;
      for (int k = 0; k < 3000 && !cmd_ready; k++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b0) bad++;
      end
      check("abort_no_stale_rsp", 64'(bad), 64'd0);
      check("abort_init_rises", 64'(rises - r0), 64'd6);
      check("abort_init_tms", 64'(tms_log[5:0]), 64'b11_1110);
      send(2'd3, 7'd32, 64'h0, "after_abort", ok);
      if (ok) wait_rsp("after_abort", ok);
      if (ok) begin
        check("after_abort_data", rsp_data, 64'h1025);
        take_rsp();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
